// File: rtl/rv32i_fetch_queue.sv
// RV32I instruction-fetch stage: fetch PC, single-outstanding imem requests, prefetch queue.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module rv32i_fetch_queue #(
    parameter int unsigned     DPW       = 32,
    parameter int unsigned     ADW       = 32,
    parameter logic [ADW-1:0]  RESET_PC  = '0,
    parameter int unsigned     QDEPTH    = 4,
    parameter logic [DPW-1:0]  NOP_INSTR = 'h13
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flushF,
    input  logic [ADW-1:0] PCNext,
    input  logic           stallF,
    output logic           imem_req,
    output logic [ADW-1:0] imem_addr,
    input  logic           imem_ack,
    input  logic [DPW-1:0] imem_rdata,
    output logic           instr_valid,
    output logic [ADW-1:0] PCF,
    output logic [DPW-1:0] instr
`ifdef FETCH_PERF_CNT_EN
  , output logic [31:0]    perf_fetched,
    output logic [31:0]    perf_bubble
`endif
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t          state_q, state_d;
    logic [ADW-1:0]  fpc_q, fpc_d;
    logic [ADW-1:0]  addr_q, addr_d;
    logic            discard_q, discard_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [ADW-1:0]  pc_mem_q  [QDEPTH];
    logic [DPW-1:0]  dat_mem_q [QDEPTH];
    logic            push, pop;

    assign imem_req    = (state_q == WAIT);
    assign imem_addr   = addr_q;
    assign instr_valid = (count_q != '0);
    assign PCF         = instr_valid ? pc_mem_q[rd_ptr_q]  : fpc_q;
    assign instr       = instr_valid ? dat_mem_q[rd_ptr_q] : NOP_INSTR;

    always_comb begin
        state_d   = state_q;
        fpc_d     = fpc_q;
        addr_d    = addr_q;
        discard_d = discard_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        push      = 1'b0;
        pop       = instr_valid && !stallF && !flushF;

        unique case (state_q)
            // A flush in IDLE defers issue one cycle so the new fpc is what goes out.
            IDLE: if (!flushF && count_q < CW'(QDEPTH)) begin
                state_d = WAIT;
                addr_d  = fpc_q;
            end
            WAIT: if (imem_ack) begin
                state_d   = IDLE;
                push      = !discard_q && !flushF;
                discard_d = 1'b0;
            end else if (flushF) begin
                discard_d = 1'b1;
            end
        endcase

        if (flushF) begin
            fpc_d    = PCNext & ~ADW'(3);
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) begin
                fpc_d    = fpc_q + ADW'(4);
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            fpc_q     <= RESET_PC;
            addr_q    <= RESET_PC;
            discard_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            fpc_q     <= fpc_d;
            addr_q    <= addr_d;
            discard_q <= discard_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Pushed PC is the latched request address, which equals fpc whenever the word is kept.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]  <= addr_q;
            dat_mem_q[wr_ptr_q] <= imem_rdata;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_bubble_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_bubble_q  <= '0;
        end else begin
            if (pop && perf_fetched_q != '1) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (!instr_valid && !stallF && perf_bubble_q != '1) begin
                perf_bubble_q <= perf_bubble_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_bubble  = perf_bubble_q;
`endif

endmodule

// File: tb/tb_rv32i_fetch_queue.sv
// Scoreboard bench for rv32i_fetch_queue: a driver responds as instruction memory and
// pushes expected {PC, word} entries; a monitor pops them as decode consumes the head.
module tb_rv32i_fetch_queue;

    localparam int QD = 4;

    logic        clk = 1'b0;
    logic        rst, flushF, stallF, imem_ack, imem_req, instr_valid;
    logic [31:0] PCNext, imem_addr, imem_rdata, PCF, instr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_bubble;
`endif

    always #5 clk = ~clk;

    rv32i_fetch_queue #(
        .DPW(32), .ADW(32), .RESET_PC(32'h0), .QDEPTH(QD), .NOP_INSTR(32'h13)
    ) dut (
        .clk(clk), .rst(rst), .flushF(flushF), .PCNext(PCNext), .stallF(stallF),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr_valid(instr_valid), .PCF(PCF), .instr(instr)
`ifdef FETCH_PERF_CNT_EN
      , .perf_fetched(perf_fetched), .perf_bubble(perf_bubble)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        int          rdy;
    } ent_t;

    ent_t        sb[$];
    int          checks = 0, errors = 0;
    int          cyc = 0;
    int          exp_fetched = 0, exp_bubble = 0;
    logic [31:0] exp_fpc = '0;
    bit          discard = 0;
    int          stall_mode = 0, ack_mode = 0;
    bit          rand_flush = 0, flush_req = 0, flush_busy = 0, seen_noack = 0;
    logic [31:0] flush_pc = '0;
    logic [31:0] noack_addr = 32'h1;
    bit          hv;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic fail_to(input string nm);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", nm);
    endtask

    // One clock of stimulus; model state advances with what the DUT will see at the next edge.
    task automatic step();
        @(negedge clk); #1;
        cyc++;
        rst    = 1'b0;
        stallF = (stall_mode == 2) ? ($urandom_range(0, 3) == 0) : (stall_mode == 1);
        if (imem_req && imem_addr == noack_addr) seen_noack = 1;
        imem_ack = imem_req && imem_addr != noack_addr &&
                   (ack_mode == 0 || (ack_mode == 1 && $urandom_range(0, 2) == 0));
        imem_rdata = imem_ack ? memword(imem_addr) : $urandom;
        if (flush_busy && imem_req && instr_valid && !stallF) begin
            flush_req  = 1;
            flush_busy = 0;
        end
        if (rand_flush && $urandom_range(0, 19) == 0) begin
            flush_req = 1;
            flush_pc  = $urandom;
        end
        flushF    = flush_req;
        PCNext    = flush_pc;
        flush_req = 0;

        if (imem_req) chk("req_not_full", 32'(sb.size() < QD), 32'd1);
        if (imem_ack && !discard) chk("imem_addr", imem_addr, exp_fpc);
        if (flushF) begin
            discard = imem_req && !imem_ack;
            exp_fpc = {PCNext[31:2], 2'b00};
        end else if (imem_ack) begin
            if (discard) begin
                discard = 0;
            end else begin
                sb.push_back('{pc: exp_fpc, word: memword(exp_fpc), rdy: cyc + 1});
                exp_fpc = exp_fpc + 32'd4;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        cyc++;
        rst = 1'b1; flushF = 1'b0; stallF = 1'b0; imem_ack = 1'b0;
        flush_req = 0; flush_busy = 0; discard = 0; exp_fpc = '0;
        exp_fetched = 0; exp_bubble = 0;
        sb.delete();
        @(posedge clk); #1;
        chk("rst_imem_req", imem_req, 0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_PCF", PCF, 32'h0);
        chk("rst_instr", instr, 32'h13);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_perf_fetched", perf_fetched, 0);
        chk("rst_perf_bubble", perf_bubble, 0);
`endif
    endtask

    // Monitor: sees the outputs plus the inputs about to be clocked in.
    initial forever begin
        @(negedge clk); #2;
        if (rst !== 1'b1) begin
            hv = sb.size() > 0 && sb[0].rdy <= cyc;
            if (!hv && !stallF) exp_bubble++;
            if (!flushF) begin
                if (hv) begin
                    chk("head_valid", instr_valid, 1);
                    if (!stallF) begin
                        chk("pop_PCF", PCF, sb[0].pc);
                        chk("pop_instr", instr, sb[0].word);
                        void'(sb.pop_front());
                        exp_fetched++;
                    end
                end else begin
                    chk("empty_valid", instr_valid, 0);
                    chk("empty_nop", instr, 32'h13);
                end
            end else begin
                sb.delete();
            end
        end
    end

    initial begin
        rst = 1'b1; flushF = 1'b0; PCNext = '0; stallF = 1'b0; imem_ack = 1'b0; imem_rdata = '0;

        // Streaming with immediate acks: first valid two cycles after reset release.
        stall_mode = 0; ack_mode = 0;
        do_reset();
        step(); step();
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 32'h0);
        chk("valid_latency_early", instr_valid, 0);
        step();
        chk("valid_latency", instr_valid, 1);
        repeat (20) step();

        // Stalled decode fills the queue and throttles requests.
        do_reset();
        stall_mode = 1;
        repeat (10) step();
        chk("full_req_low", imem_req, 0);
        chk("full_head_pc", PCF, 32'h0);
        chk("full_words", sb.size(), QD);
        stall_mode = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("release_pcf", PCF, 32'(4 * i));
        end
        repeat (6) step();

        // Redirect while waiting on 0x10; the late word is dropped.
        do_reset();
        noack_addr = 32'h10; seen_noack = 0;
        for (int i = 0; i < 60 && !seen_noack; i++) step();
        if (!seen_noack) fail_to("wait_on_0x10");
        flush_req = 1; flush_pc = 32'h103;
        step(); step(); step();
        noack_addr = 32'h1;
        step();
        begin
            bit got = 0;
            for (int i = 0; i < 10 && !got; i++) begin step(); got = imem_req; end
            if (got) chk("redirect_addr", imem_addr, 32'h100); else fail_to("redirect_req");
            got = 0;
            for (int i = 0; i < 10 && !got; i++) begin step(); got = instr_valid; end
            if (got) chk("redirect_pcf", PCF, 32'h100); else fail_to("redirect_valid");
        end

        // Flush coinciding with ack and pop.
        do_reset();
        stall_mode = 1;
        repeat (6) step();
        stall_mode = 0; flush_pc = 32'h200; flush_busy = 1;
        for (int i = 0; i < 20 && flush_busy; i++) step();
        if (flush_busy) begin
            fail_to("flush_ack_pop");
            flush_busy = 0;
        end else begin
            @(posedge clk); #1;
            chk("flush_empty", instr_valid, 0);
        end
        begin
            bit got = 0;
            for (int i = 0; i < 10 && !got; i++) begin step(); got = imem_req; end
            if (got) chk("flush_refetch", imem_addr, 32'h200); else fail_to("flush_refetch_req");
        end
        repeat (10) step();

        // PC wrap and reset while a request is outstanding.
        do_reset();
        flush_req = 1; flush_pc = 32'hFFFF_FFFE;
        step();
        begin
            bit got = 0;
            for (int i = 0; i < 10 && !got; i++) begin step(); got = imem_req; end
            if (got) chk("wrap_top_addr", imem_addr, 32'hFFFF_FFFC); else fail_to("wrap_top_req");
            ack_mode = 2; got = 0;
            for (int i = 0; i < 10 && !got; i++) begin step(); got = imem_req; end
            if (got) chk("wrap_zero_addr", imem_addr, 32'h0); else fail_to("wrap_zero_req");
        end
        do_reset();

        // Randomised traffic with stalls, variable ack latency and redirects.
        stall_mode = 2; ack_mode = 1; rand_flush = 1;
        repeat (3000) step();
        rand_flush = 0; stall_mode = 0; ack_mode = 0;
        repeat (30) step();
        @(posedge clk); #1;
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, exp_fetched);
        chk("perf_bubble", perf_bubble, exp_bubble);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
